branch_resolve_unit: RTL and testbench

- Execute-to-memory stage directly downstream of the ALU; consumes the ALU result and branch decision for the instruction in EX.
- Registers the EX/MEM result and resolves control flow against the fetch-time prediction.
- Issues a one-cycle flush/redirect on mispredict.
- Owns a small direct-mapped 2-bit branch history table (BHT), read combinationally by fetch.

---
 rtl/branch_resolve_unit.sv | 152 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_unit
//  Purpose  : EX/MEM register with branch resolution, one-cycle mispredict
//             flush/redirect and a direct-mapped 2-bit branch history table.
//             Optional performance counters: define BRU_PERF_COUNTERS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int BHT_ENTRIES   = 16,
    parameter int BHT_INDEX_LSB = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic [31:0] alu_result,
    input  logic        alu_branch_enable,
    input  logic        stall,

    input  logic [31:0] fetch_pc,
    output logic        fetch_pred_taken,

    output logic        mem_valid,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_link,
    output logic        flush,
    output logic [31:0] redirect_pc,

    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    localparam int         c_idx_w     = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
    localparam logic [1:0] c_ctr_reset = 2'b01;
    localparam logic [1:0] c_ctr_max   = 2'b11;
    localparam logic [1:0] c_ctr_min   = 2'b00;

    logic               r_mem_valid;
    logic [31:0]        r_mem_alu_result;
    logic [31:0]        r_mem_link;
    logic               r_flush;
    logic [31:0]        r_redirect_pc;
    logic [1:0]         r_bht [BHT_ENTRIES];

    logic               w_accept;
    logic               w_actual_taken;
    logic               w_mispredict;
    logic               w_bht_we;
    logic [31:0]        w_link;
    logic [c_idx_w-1:0] w_fetch_idx;
    logic [c_idx_w-1:0] w_ex_idx;
    logic [1:0]         w_ctr_cur;
    logic [1:0]         w_ctr_next;
    logic               w_unused_fetch;

    // Anything sitting in EX while a flush is visible is on the wrong path.
    assign w_accept       = ex_valid & ~stall & ~r_flush;
    // A simultaneous branch+jump encoding resolves as a jump.
    assign w_actual_taken = ex_is_jump | (ex_is_branch & alu_branch_enable);
    assign w_mispredict   = w_actual_taken ^ ex_pred_taken;
    assign w_bht_we       = w_accept & ex_is_branch & ~ex_is_jump;
    assign w_link         = ex_pc + 32'd4;

    assign w_fetch_idx    = fetch_pc[BHT_INDEX_LSB +: c_idx_w];
    assign w_ex_idx       = ex_pc[BHT_INDEX_LSB +: c_idx_w];
    assign w_unused_fetch = ^fetch_pc;

    // Reads the stored counter, so a same-cycle update is not bypassed.
    assign fetch_pred_taken = r_bht[w_fetch_idx][1];
    assign w_ctr_cur        = r_bht[w_ex_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (w_actual_taken) begin
            if (w_ctr_cur != c_ctr_max) begin
                w_ctr_next = w_ctr_cur + 2'd1;
            end
        end else if (w_ctr_cur != c_ctr_min) begin
            w_ctr_next = w_ctr_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_valid      <= 1'b0;
            r_mem_alu_result <= '0;
            r_mem_link       <= '0;
            r_flush          <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            // Accept is low whenever stall is high, so flush always self-clears.
            r_flush <= w_accept & w_mispredict;
            if (w_accept) begin
                r_mem_valid      <= 1'b1;
                r_mem_alu_result <= alu_result;
                r_mem_link       <= w_link;
                r_redirect_pc    <= w_actual_taken ? ex_target : w_link;
            end else if (!stall) begin
                r_mem_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= c_ctr_reset;
            end
        end else if (w_bht_we) begin
            r_bht[w_ex_idx] <= w_ctr_next;
        end
    end

    assign mem_valid      = r_mem_valid;
    assign mem_alu_result = r_mem_alu_result;
    assign mem_link       = r_mem_link;
    assign flush          = r_flush;
    assign redirect_pc    = r_redirect_pc;

`ifdef BRU_PERF_COUNTERS_EN
    logic [31:0] r_perf_branches;
    logic [31:0] r_perf_mispredicts;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_branches    <= '0;
            r_perf_mispredicts <= '0;
        end else begin
            if (w_accept & (ex_is_branch | ex_is_jump)) begin
                r_perf_branches <= r_perf_branches + 32'd1;
            end
            if (w_accept & w_mispredict) begin
                r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
            end
        end
    end

    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;
`else
    assign perf_branches    = '0;
    assign perf_mispredicts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolve_unit
//  Purpose  : Self-checking bench: vector table with scoreboard queue plus
//             hand-written sequences for BHT, stall, wrong-path and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, alu_result;
    logic        alu_branch_enable, stall;
    logic [31:0] fetch_pc;
    logic        fetch_pred_taken;
    logic        mem_valid;
    logic [31:0] mem_alu_result, mem_link, redirect_pc;
    logic        flush;
    logic [31:0] perf_branches, perf_mispredicts;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.BHT_ENTRIES(16), .BHT_INDEX_LSB(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .ex_valid          (ex_valid),
        .ex_is_branch      (ex_is_branch),
        .ex_is_jump        (ex_is_jump),
        .ex_pred_taken     (ex_pred_taken),
        .ex_pc             (ex_pc),
        .ex_target         (ex_target),
        .alu_result        (alu_result),
        .alu_branch_enable (alu_branch_enable),
        .stall             (stall),
        .fetch_pc          (fetch_pc),
        .fetch_pred_taken  (fetch_pred_taken),
        .mem_valid         (mem_valid),
        .mem_alu_result    (mem_alu_result),
        .mem_link          (mem_link),
        .flush             (flush),
        .redirect_pc       (redirect_pc),
        .perf_branches     (perf_branches),
        .perf_mispredicts  (perf_mispredicts)
    );

    typedef struct {
        logic        v, br, j, pred;
        logic [31:0] pc, tgt, alu;
        logic        en, st;
        logic        mv;
        logic [31:0] malu, mlink;
        logic        fl;
        logic [31:0] rpc;
    } vec_t;

    typedef struct {
        logic        mv;
        logic [31:0] malu, mlink;
        logic        fl;
        logic [31:0] rpc;
    } exp_t;

    vec_t tbl [17];
    exp_t sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic br, input logic j, input logic pred,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] alu,
                         input logic en, input logic st);
        ex_valid = v; ex_is_branch = br; ex_is_jump = j; ex_pred_taken = pred;
        ex_pc = pc; ex_target = tgt; alu_result = alu; alu_branch_enable = en; stall = st;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Step one clock: drive at negedge, sample 1 time unit after posedge.
    task automatic cycle(input logic v, input logic br, input logic j, input logic pred,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] alu,
                         input logic en, input logic st);
        @(negedge clk);
        drive(v, br, j, pred, pc, tgt, alu, en, st);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pred(input string name, input logic [31:0] pc, input logic exp);
        fetch_pc = pc;
        #1;
        check(name, {31'b0, fetch_pred_taken}, {31'b0, exp});
    endtask

    task automatic chk_perf(input string name, input logic [31:0] br, input logic [31:0] mp);
`ifdef BRU_PERF_COUNTERS_EN
        check({name, "_branches"}, perf_branches, br);
        check({name, "_mispredicts"}, perf_mispredicts, mp);
`else
        check({name, "_branches"}, perf_branches, 32'h0);
        check({name, "_mispredicts"}, perf_mispredicts, 32'h0);
        if (br === 32'hx || mp === 32'hx) $display("unexpected perf expectation");
`endif
    endtask

    initial begin
        exp_t e;

        //          v  br j  p  pc            tgt           alu           en st   mv malu          mlink         fl rpc
        tbl[0]  = '{1, 0, 0, 0, 32'h00001000, 32'h00000000, 32'h00000011, 0, 0,   1, 32'h00000011, 32'h00001004, 0, 32'h0};
        tbl[1]  = '{0, 0, 0, 0, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0,   0, 32'h00000011, 32'h00001004, 0, 32'h0};
        tbl[2]  = '{1, 1, 0, 0, 32'h00002008, 32'h00003000, 32'h00000022, 0, 0,   1, 32'h00000022, 32'h0000200C, 0, 32'h0};
        tbl[3]  = '{1, 1, 0, 1, 32'h00002010, 32'h00002400, 32'h00000033, 1, 0,   1, 32'h00000033, 32'h00002014, 0, 32'h0};
        tbl[4]  = '{1, 0, 0, 1, 32'h00003000, 32'h00003800, 32'h00000044, 0, 0,   1, 32'h00000044, 32'h00003004, 1, 32'h00003004};
        tbl[5]  = '{1, 1, 0, 0, 32'h00005004, 32'h00005800, 32'h00000055, 1, 0,   0, 32'h00000044, 32'h00003004, 0, 32'h0};
        tbl[6]  = '{1, 0, 0, 0, 32'h00006000, 32'h00000000, 32'h00000066, 0, 1,   0, 32'h00000044, 32'h00003004, 0, 32'h0};
        tbl[7]  = '{1, 0, 0, 0, 32'h00006000, 32'h00000000, 32'h00000066, 0, 0,   1, 32'h00000066, 32'h00006004, 0, 32'h0};
        tbl[8]  = '{1, 0, 1, 0, 32'h00007000, 32'h00008000, 32'h00000077, 0, 0,   1, 32'h00000077, 32'h00007004, 1, 32'h00008000};
        tbl[9]  = '{0, 0, 0, 0, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0,   0, 32'h00000077, 32'h00007004, 0, 32'h0};
        tbl[10] = '{1, 1, 1, 1, 32'h00009004, 32'h00009100, 32'h00000099, 1, 0,   1, 32'h00000099, 32'h00009008, 0, 32'h0};
        tbl[11] = '{1, 0, 0, 0, 32'h0000A000, 32'h00000000, 32'h000000AA, 0, 1,   1, 32'h00000099, 32'h00009008, 0, 32'h0};
        tbl[12] = '{1, 1, 0, 1, 32'h0000B00C, 32'h0000C000, 32'h000000BB, 0, 0,   1, 32'h000000BB, 32'h0000B010, 1, 32'h0000B010};
        tbl[13] = '{1, 0, 0, 0, 32'h0000D000, 32'h00000000, 32'h000000DD, 0, 1,   1, 32'h000000BB, 32'h0000B010, 0, 32'h0};
        tbl[14] = '{0, 0, 0, 0, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0,   0, 32'h000000BB, 32'h0000B010, 0, 32'h0};
        tbl[15] = '{1, 0, 0, 1, 32'hFFFFFFFC, 32'h00000000, 32'h000000EE, 0, 0,   1, 32'h000000EE, 32'h00000000, 1, 32'h00000000};
        tbl[16] = '{0, 0, 0, 0, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0,   0, 32'h000000EE, 32'h00000000, 0, 32'h0};

        // Reset held for 3 cycles
        reset = 1'b1;
        fetch_pc = 32'h0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
        check("rst_mem_alu_result", mem_alu_result, 32'h0);
        check("rst_mem_link", mem_link, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        chk_perf("rst", 32'd0, 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk_pred($sformatf("rst_pred_idx%0d", i), 32'(i) << 2, 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Table vectors through the scoreboard
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].br, tbl[i].j, tbl[i].pred, tbl[i].pc, tbl[i].tgt,
                  tbl[i].alu, tbl[i].en, tbl[i].st);
            sb.push_back('{tbl[i].mv, tbl[i].malu, tbl[i].mlink, tbl[i].fl, tbl[i].rpc});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d_mem_valid", i), {31'b0, mem_valid}, {31'b0, e.mv});
            check($sformatf("vec%0d_mem_alu_result", i), mem_alu_result, e.malu);
            check($sformatf("vec%0d_mem_link", i), mem_link, e.mlink);
            check($sformatf("vec%0d_flush", i), {31'b0, flush}, {31'b0, e.fl});
            if (e.fl) check($sformatf("vec%0d_redirect_pc", i), redirect_pc, e.rpc);
        end
        chk_pred("tbl_pred_idx0", 32'h00, 1'b0);
        chk_pred("tbl_pred_idx1", 32'h04, 1'b0);
        chk_pred("tbl_pred_idx2", 32'h08, 1'b0);
        chk_pred("tbl_pred_idx3", 32'h0C, 1'b0);
        chk_pred("tbl_pred_idx4", 32'h10, 1'b1);
        chk_perf("tbl", 32'd5, 32'd4);

        // BEQ at 0x100 mispredicted taken, then BHT saturation
        cycle(1, 1, 0, 0, 32'h100, 32'h80, 32'h01, 1, 0);
        check("beq_flush", {31'b0, flush}, 32'h1);
        check("beq_redirect_pc", redirect_pc, 32'h80);
        check("beq_mem_link", mem_link, 32'h104);
        cycle(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        check("beq_flush_clear", {31'b0, flush}, 32'h0);
        chk_pred("beq_pred_10", 32'h100, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 0, 1, 32'h100, 32'h80, 32'h02, 1, 0);
            check($sformatf("beq_taken%0d_flush", k), {31'b0, flush}, 32'h0);
        end
        @(negedge clk);
        drive(1, 1, 0, 1, 32'h100, 32'h80, 32'h03, 0, 0);
        chk_pred("collision_pre_update", 32'h100, 1'b1);
        @(posedge clk);
        #1;
        check("beq_nt_flush", {31'b0, flush}, 32'h1);
        check("beq_nt_redirect_pc", redirect_pc, 32'h104);
        cycle(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        chk_pred("beq_pred_after_sat", 32'h100, 1'b1);
        cycle(1, 1, 0, 0, 32'h100, 32'h80, 32'h10, 0, 0);
        check("beq_nt2_flush", {31'b0, flush}, 32'h0);
        chk_pred("beq_pred_01", 32'h100, 1'b0);

        // JAL under stall
        for (int k = 0; k < 2; k++) begin
            cycle(1, 0, 1, 0, 32'h200, 32'h400, 32'h20, 0, 1);
            check($sformatf("jal_stall%0d_flush", k), {31'b0, flush}, 32'h0);
            check($sformatf("jal_stall%0d_mem_valid", k), {31'b0, mem_valid}, 32'h1);
            check($sformatf("jal_stall%0d_alu", k), mem_alu_result, 32'h10);
            check($sformatf("jal_stall%0d_link", k), mem_link, 32'h104);
        end
        cycle(1, 0, 1, 0, 32'h200, 32'h400, 32'h20, 0, 0);
        check("jal_flush", {31'b0, flush}, 32'h1);
        check("jal_redirect_pc", redirect_pc, 32'h400);
        check("jal_link", mem_link, 32'h204);

        // Wrong-path instruction while flush is high
        cycle(1, 1, 0, 0, 32'h300, 32'h500, 32'h30, 1, 0);
        check("wp_mem_valid", {31'b0, mem_valid}, 32'h0);
        check("wp_flush", {31'b0, flush}, 32'h0);
        check("wp_alu_hold", mem_alu_result, 32'h20);
        chk_pred("wp_no_bht_update", 32'h300, 1'b0);

        // Branch at 0x1FC, predicted taken, falls through
        cycle(1, 1, 0, 1, 32'h1FC, 32'h900, 32'h40, 0, 0);
        check("b1fc_flush", {31'b0, flush}, 32'h1);
        check("b1fc_redirect_pc", redirect_pc, 32'h200);
        check("b1fc_link", mem_link, 32'h200);
        chk_perf("final", 32'd13, 32'd8);
        cycle(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);

        // Reset coincident with a mispredicting accept
        @(negedge clk);
        drive(1, 1, 0, 0, 32'h104, 32'h600, 32'h50, 1, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_flush", {31'b0, flush}, 32'h0);
        check("midrst_mem_valid", {31'b0, mem_valid}, 32'h0);
        check("midrst_link", mem_link, 32'h0);
        chk_pred("midrst_bht_reinit", 32'h10, 1'b0);
        chk_perf("midrst", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
